// File: rtl/uart_rsp_framer_pkg.sv
// Shared types and constants for the UART response framer.
// Status-bit positions and frame lengths are used by the RTL and by anything that parses the frames.
package uart_rsp_framer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STATUS = 2'd1,
    DATA   = 2'd2,
    CSUM   = 2'd3
  } state_t;

  localparam int IS_READ  = 0;
  localparam int ERR      = 1;
  localparam int INTG_ERR = 2;

  localparam int DATA_BYTES      = 4;
  localparam int FRAME_LEN_SHORT = 2;
  localparam int FRAME_LEN_READ  = DATA_BYTES + 2;

endpackage

// File: rtl/uart_rsp_framer.sv
// Turns one bus response into a framed byte stream: status, optional read data (LSB first), XOR checksum.
// Responses that arrive while a frame is in flight are dropped and counted.
module uart_rsp_framer
  import uart_rsp_framer_pkg::*;
#(
  parameter logic [3:0] STATUS_TAG = 4'hA,
  parameter int         DROP_CNT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rsp_valid_i,
  output logic                  rsp_ready_o,
  input  logic                  rsp_is_read_i,
  input  logic [31:0]           rsp_rdata_i,
  input  logic                  rsp_err_i,
  input  logic                  rsp_intg_err_i,
  output logic                  tx_valid_o,
  output logic [7:0]            tx_data_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  state_t                r_state;
  logic [31:0]           r_rdata;
  logic                  r_isRead;
  logic                  r_err;
  logic                  r_intgErr;
  logic                  r_txValid;
  logic [7:0]            r_txData;
  logic [7:0]            r_csum;
  logic [1:0]            r_idx;
  logic                  r_frameDone;
  logic [DROP_CNT_W-1:0] r_dropCnt;

  state_t                w_nextState;
  logic                  w_nextTxValid;
  logic [7:0]            w_nextTxData;
  logic [7:0]            w_nextCsum;
  logic [1:0]            w_nextIdx;
  logic                  w_nextFrameDone;
  logic                  w_capture;
  logic                  w_drop;
  logic                  w_xfer;
  logic                  w_goodRead;
  logic [7:0]            w_status;
  logic [1:0]            w_idxInc;
  logic [7:0]            w_firstByte;
  logic [7:0]            w_nextByte;

  assign w_capture   = rsp_valid_i && (r_state == IDLE);
  assign w_drop      = rsp_valid_i && (r_state != IDLE);
  assign w_xfer      = r_txValid && tx_ready_i;
  assign w_goodRead  = r_isRead && !r_err && !r_intgErr;
  assign w_idxInc    = r_idx + 2'd1;
  assign w_firstByte = r_rdata[7:0];
  assign w_nextByte  = r_rdata[{w_idxInc, 3'b000} +: 8];

  always_comb begin
    w_status                = '0;
    w_status[7:4]           = STATUS_TAG;
    w_status[INTG_ERR]      = rsp_intg_err_i;
    w_status[ERR]           = rsp_err_i;
    w_status[IS_READ]       = rsp_is_read_i;
  end

  // Data bytes fold into the checksum as they are loaded, so CSUM can present r_csum directly.
  always_comb begin
    w_nextState     = r_state;
    w_nextTxValid   = r_txValid;
    w_nextTxData    = r_txData;
    w_nextCsum      = r_csum;
    w_nextIdx       = r_idx;
    w_nextFrameDone = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_capture) begin
          w_nextState   = STATUS;
          w_nextTxValid = 1'b1;
          w_nextTxData  = w_status;
          w_nextCsum    = w_status;
          w_nextIdx     = 2'd0;
        end
      end
      STATUS: begin
        if (w_xfer) begin
          if (w_goodRead) begin
            w_nextState  = DATA;
            w_nextTxData = w_firstByte;
            w_nextCsum   = r_csum ^ w_firstByte;
            w_nextIdx    = 2'd0;
          end else begin
            w_nextState  = CSUM;
            w_nextTxData = r_csum;
          end
        end
      end
      DATA: begin
        if (w_xfer) begin
          if (r_idx == 2'(DATA_BYTES - 1)) begin
            w_nextState  = CSUM;
            w_nextTxData = r_csum;
          end else begin
            w_nextIdx    = w_idxInc;
            w_nextTxData = w_nextByte;
            w_nextCsum   = r_csum ^ w_nextByte;
          end
        end
      end
      CSUM: begin
        if (w_xfer) begin
          w_nextState     = IDLE;
          w_nextTxValid   = 1'b0;
          w_nextFrameDone = 1'b1;
        end
      end
      default: begin
        w_nextState   = IDLE;
        w_nextTxValid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_txValid   <= 1'b0;
      r_txData    <= '0;
      r_csum      <= '0;
      r_idx       <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_txValid   <= w_nextTxValid;
      r_txData    <= w_nextTxData;
      r_csum      <= w_nextCsum;
      r_idx       <= w_nextIdx;
      r_frameDone <= w_nextFrameDone;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata   <= '0;
      r_isRead  <= 1'b0;
      r_err     <= 1'b0;
      r_intgErr <= 1'b0;
    end else if (w_capture) begin
      r_rdata   <= rsp_rdata_i;
      r_isRead  <= rsp_is_read_i;
      r_err     <= rsp_err_i;
      r_intgErr <= rsp_intg_err_i;
    end
  end

  // A response landing on the final CSUM transfer still counts: the state is not IDLE yet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dropCnt <= '0;
    end else if (w_drop && (r_dropCnt != '1)) begin
      r_dropCnt <= r_dropCnt + 1'b1;
    end
  end

  assign rsp_ready_o  = (r_state == IDLE);
  assign busy_o       = (r_state != IDLE);
  assign tx_valid_o   = r_txValid;
  assign tx_data_o    = r_txData;
  assign frame_done_o = r_frameDone;
  assign drop_cnt_o   = r_dropCnt;

endmodule

// File: tb/tb_uart_rsp_framer.sv
// Randomised scoreboard bench for uart_rsp_framer: a frame model fills a queue, a monitor drains it.
module tb_uart_rsp_framer;
  import uart_rsp_framer_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rsp_valid_i;
  logic        rsp_ready_o;
  logic        rsp_is_read_i;
  logic [31:0] rsp_rdata_i;
  logic        rsp_err_i;
  logic        rsp_intg_err_i;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic        busy_o;
  logic        frame_done_o;
  logic [7:0]  drop_cnt_o;

  typedef struct {
    logic [7:0] data;
    bit         last;
  } exp_t;

  exp_t       sbQueue[$];
  int         testsRun  = 0;
  int         failCount = 0;
  int         readyMode = 0;
  int         dropExp   = 0;
  bit         prevStall = 1'b0;
  logic [7:0] prevData  = 8'h00;
  bit         doneExp   = 1'b0;

  uart_rsp_framer #(.STATUS_TAG(4'hA), .DROP_CNT_W(8)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rsp_valid_i    (rsp_valid_i),
    .rsp_ready_o    (rsp_ready_o),
    .rsp_is_read_i  (rsp_is_read_i),
    .rsp_rdata_i    (rsp_rdata_i),
    .rsp_err_i      (rsp_err_i),
    .rsp_intg_err_i (rsp_intg_err_i),
    .tx_valid_o     (tx_valid_o),
    .tx_data_o      (tx_data_o),
    .tx_ready_i     (tx_ready_i),
    .busy_o         (busy_o),
    .frame_done_o   (frame_done_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: status byte, data bytes only for clean reads, then XOR of everything before it.
  function automatic void modelFrame(input bit isRead, input logic [31:0] rdata,
                                     input bit err, input bit intg);
    logic [7:0] bytes[$];
    logic [7:0] csum;
    exp_t       e;
    bytes.push_back({4'hA, 1'b0, intg, err, isRead});
    if (isRead && !err && !intg)
      for (int i = 0; i < 4; i++) bytes.push_back(rdata[8*i +: 8]);
    csum = 8'h00;
    foreach (bytes[i]) csum = csum ^ bytes[i];
    bytes.push_back(csum);
    foreach (bytes[i]) begin
      e.data = bytes[i];
      e.last = (i == bytes.size() - 1);
      sbQueue.push_back(e);
    end
  endfunction

  // Ready pattern generator, retimed just after each rising edge.
  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      case (readyMode)
        0:       tx_ready_i = 1'b1;
        1:       tx_ready_i = 1'($urandom_range(0, 1));
        default: tx_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: pops an expected byte on every transfer and checks hold-stable and done-pulse behaviour.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prevStall = 1'b0;
        doneExp   = 1'b0;
      end else begin
        checkOutput("frameDone", 32'(frame_done_o), 32'(doneExp));
        if (prevStall) begin
          checkOutput("holdValid", 32'(tx_valid_o), 32'd1);
          checkOutput("holdData", 32'(tx_data_o), 32'(prevData));
        end
        doneExp = 1'b0;
        if (tx_valid_o && tx_ready_i) begin
          if (sbQueue.size() == 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL unexpectedByte: got 0x%0h, expected no byte at %0t", tx_data_o, $time);
          end else begin
            e = sbQueue.pop_front();
            checkOutput("txByte", 32'(tx_data_o), 32'(e.data));
            doneExp = e.last;
          end
        end
        prevStall = tx_valid_o && !tx_ready_i;
        prevData  = tx_data_o;
      end
    end
  end

  // Issues one response pulse while the framer is known to be idle, then checks capture latency.
  task automatic applyStimulus(input bit isRead, input logic [31:0] rdata, input bit err, input bit intg);
    @(negedge clk_i);
    checkOutput("rspReady", 32'(rsp_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    rsp_valid_i    = 1'b1;
    rsp_is_read_i  = isRead;
    rsp_rdata_i    = rdata;
    rsp_err_i      = err;
    rsp_intg_err_i = intg;
    modelFrame(isRead, rdata, err, intg);
    @(posedge clk_i);
    #1;
    rsp_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("captureValid", 32'(tx_valid_o), 32'd1);
    checkOutput("captureBusy", 32'(busy_o), 32'd1);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (sbQueue.size() != 0 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (sbQueue.size() != 0) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL idleTimeout: %0d bytes still pending, expected 0", sbQueue.size());
      sbQueue.delete();
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic measureFrame(input int expLen);
    int n = 0;
    while (!frame_done_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("frameLen", 32'(n), 32'(expLen));
  endtask

  initial begin
    rst_i          = 1'b1;
    rsp_valid_i    = 1'b0;
    rsp_is_read_i  = 1'b0;
    rsp_rdata_i    = '0;
    rsp_err_i      = 1'b0;
    rsp_intg_err_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rstTxValid", 32'(tx_valid_o), 32'd0);
    checkOutput("rstTxData", 32'(tx_data_o), 32'd0);
    checkOutput("rstFrameDone", 32'(frame_done_o), 32'd0);
    checkOutput("rstDropCnt", 32'(drop_cnt_o), 32'd0);
    checkOutput("rstBusy", 32'(busy_o), 32'd0);
    checkOutput("rstReady", 32'(rsp_ready_o), 32'd1);

    // Directed frames with ready held high.
    readyMode = 0;
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    measureFrame(FRAME_LEN_READ);
    waitIdle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    measureFrame(FRAME_LEN_SHORT);
    waitIdle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    waitIdle();
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    measureFrame(FRAME_LEN_SHORT);
    waitIdle();
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    waitIdle();
    applyStimulus(1'b1, 32'hCAFE_F00D, 1'b1, 1'b1);
    waitIdle();

    // Good read under random backpressure.
    readyMode = 1;
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    waitIdle();

    // A pulse coinciding with the CSUM transfer of a write ack is a drop.
    readyMode = 0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk_i);
    #1;
    rsp_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_valid_i = 1'b0;
    if (dropExp < 255) dropExp++;
    waitIdle();
    checkOutput("dropCoincident", 32'(drop_cnt_o), 32'(dropExp));

    // Reset after the second data byte has been transferred.
    applyStimulus(1'b1, 32'hA5A5_1234, 1'b0, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    sbQueue.delete();
    dropExp = 0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("midRstTxValid", 32'(tx_valid_o), 32'd0);
    checkOutput("midRstBusy", 32'(busy_o), 32'd0);
    checkOutput("midRstDropCnt", 32'(drop_cnt_o), 32'(dropExp));
    repeat (3) @(negedge clk_i);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    waitIdle();

    // Flood a stalled frame with responses until the drop counter saturates.
    readyMode = 2;
    applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_i);
      #1;
      rsp_valid_i    = 1'b1;
      rsp_is_read_i  = 1'($urandom_range(0, 1));
      rsp_rdata_i    = $urandom;
      rsp_err_i      = 1'($urandom_range(0, 1));
      rsp_intg_err_i = 1'($urandom_range(0, 1));
      if (dropExp < 255) dropExp++;
      @(posedge clk_i);
      #1;
      rsp_valid_i = 1'b0;
    end
    @(negedge clk_i);
    checkOutput("dropSaturate", 32'(drop_cnt_o), 32'(dropExp));
    readyMode = 1;
    waitIdle();
    checkOutput("dropHold", 32'(drop_cnt_o), 32'(dropExp));

    // Random responses under random ready patterns.
    for (int i = 0; i < 24; i++) begin
      readyMode = int'($urandom_range(0, 1));
      applyStimulus(1'($urandom_range(0, 1)), $urandom,
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      waitIdle();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/uart_rsp_framer.md
Name: uart_rsp_framer

Overview:
- Sits downstream of the host-side TL-UL adapter and upstream of the uart_core TX streaming port.
- Captures each bus response (read data or write acknowledge, plus error flags) and serialises it into a framed byte stream for return to the UART link.
- Frame format: status byte, then 4 read-data bytes LSB first (only for error-free reads), then an XOR checksum byte.
- Closes the command/response loop opened by the RX-side host bridge.

Parameters:
- STATUS_TAG, 4'hA, constant upper nibble of every status byte.
- DROP_CNT_W, 8, width of the saturating dropped-response counter.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous reset, active-high.
- rsp_valid_i  input  1  response valid; a single-cycle pulse from the adapter.
- rsp_ready_o  output  1  framer idle, response will be accepted.
- rsp_is_read_i  input  1  response belongs to a read request.
- rsp_rdata_i  input  32  read data.
- rsp_err_i  input  1  bus error.
- rsp_intg_err_i  input  1  integrity error.
- tx_valid_o  output  1  byte valid toward the UART TX stream.
- tx_data_o  output  8  byte toward the UART TX stream.
- tx_ready_i  input  1  UART TX can accept a byte.
- busy_o  output  1  frame in progress (state != IDLE).
- frame_done_o  output  1  one-cycle pulse after the checksum byte is accepted.
- drop_cnt_o  output  DROP_CNT_W  saturating count of responses dropped while busy.

Behaviour:
- Reset values: on rst_i high at a clock edge, all of the following take effect the next cycle:
  - state = IDLE
  - tx_valid_o = 0, tx_data_o = 0
  - frame_done_o = 0
  - drop_cnt_o = 0
  - checksum register = 0, byte index = 0
- Reset mid-frame aborts the frame immediately; no partial bytes are emitted after reset.
- rsp_ready_o = (state == IDLE), decoded from the registered state with no combinational path from inputs.
- Capture: when rsp_valid_i && rsp_ready_o:
  - latch rdata, is_read, err and intg_err;
  - status = {STATUS_TAG, 1'b0, intg_err, err, is_read};
  - enter STATUS;
  - tx_valid_o = 1 with tx_data_o = status on the next cycle (latency 1).
- Drop: rsp_valid_i while state != IDLE increments drop_cnt_o, saturating at all-ones. The frame in progress is unaffected.
- Byte transfer: occurs on a cycle with tx_valid_o && tx_ready_i.
  - While tx_valid_o && !tx_ready_i, tx_data_o must hold stable.
  - tx_valid_o never deasserts without a transfer, except on reset.
- FSM:
  - IDLE -> STATUS on capture.
  - STATUS -> DATA on transfer, if is_read && !err && !intg_err; otherwise STATUS -> CSUM on transfer.
  - DATA: idx 0..3 emits rdata[8*idx +: 8]. Transfer at idx 3 -> CSUM; other transfers increment idx.
  - CSUM emits the XOR of all previously emitted bytes of the frame. Transfer -> IDLE, with tx_valid_o = 0 and frame_done_o = 1 in the following cycle.
- Checksum:
  - Initialised to the status byte at capture.
  - XOR-accumulated with each data byte as it is loaded into tx_data_o.
- With tx_ready_i tied high, frame length is 2 cycles (write or error) or 6 cycles (good read).
- A new capture is possible in the cycle frame_done_o is high: rsp_ready_o is already 1.
- A simultaneous rsp_valid_i and final CSUM transfer counts as a drop, because state is not yet IDLE.
- intg_err and err both set: both status bits are set and no data bytes are sent.

Decomposition:
- Package uart_rsp_framer_pkg holds:
  - state enum {IDLE, STATUS, DATA, CSUM};
  - status bit-position localparams (IS_READ = 0, ERR = 1, INTG_ERR = 2);
  - frame length constants.
- Single flat module; no sub-module warranted.

Test Plan:
- Good read: rdata = 0x12345678, is_read = 1, tx_ready_i = 1 -> bytes A1 78 56 34 12 A9 on consecutive cycles, starting 1 cycle after capture; frame_done_o pulses once.
- Write acks: is_read = 0, err = 0 -> bytes A0 A0. Then a write with err = 1 -> A2 A2. rsp_ready_o returns to 1 after each frame.
- Read with err: is_read = 1, err = 1, rdata = 0xDEADBEEF -> bytes A3 A3 with no data bytes. Same with intg_err = 1, err = 0 -> A5 A5.
- Backpressure: good read, tx_ready_i toggling 0/1 randomly -> same 6-byte sequence, tx_data_o stable whenever valid && !ready, no byte lost or duplicated.
- Drops: 300 rsp_valid_i pulses during one stalled frame (tx_ready_i = 0) -> drop_cnt_o saturates at 255 and the frame in progress is unchanged; a pulse coincident with the CSUM transfer also counts as a drop.
- Reset mid-frame: assert rst_i after the second data byte -> next cycle tx_valid_o = 0, busy_o = 0, drop_cnt_o = 0; a following write ack frames cleanly as A0 A0.
